// File: rtl/icu_wide_if.sv
// Instruction set package and the bus interface of the wide industrial control unit.
// The ICU_LANE_MASK_EN build option lives in icu_wide.sv; nothing here depends on it.
package instructions;

  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

endpackage

interface icu_wide_if
  import instructions::*;
#(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  instruction_t     i;
  logic             write;
  logic [WIDTH-1:0] data_out;
  logic             jmp;
  logic             rtn;
  logic             flag_o;
  logic             flag_f;
  logic [WIDTH-1:0] rr_out;
  logic             skipping;

  // master: program counter / ROM side; slave: the control unit
  modport master (
    output data_in, i,
    input  write, data_out, jmp, rtn, flag_o, flag_f, rr_out, skipping
  );

  modport slave (
    input  data_in, i,
    output write, data_out, jmp, rtn, flag_o, flag_f, rr_out, skipping
  );

endinterface

// File: rtl/icu_wide.sv
// WIDTH-lane MC14500B-style control unit with registered strobes and an RTN/SKZ skip FSM.
// Build option ICU_LANE_MASK_EN: IEN/OEN become per-lane masks instead of single bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_EXEC | instruction sampled at the next edge executes
// ST_SKIP | instruction sampled at the next edge is discarded, then EXEC
module icu_wide
  import instructions::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  icu_wide_if.slave bus
);

`ifdef ICU_LANE_MASK_EN
  localparam int EN_W = WIDTH;
`else
  localparam int EN_W = 1;
`endif

  typedef enum logic {
    ST_EXEC = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rr;
  logic [EN_W-1:0]  ien_r;
  logic [EN_W-1:0]  oen_r;
  logic [WIDTH-1:0] data_out_r;
  logic             write_r;
  logic             jmp_r;
  logic             rtn_r;
  logic             flag_o_r;
  logic             flag_f_r;

  logic [WIDTH-1:0] d_eff;
  logic [EN_W-1:0]  en_load;
  logic [WIDTH-1:0] store_val;
  logic [WIDTH-1:0] store_merged;

  // IEN/OEN load straight from the bus, never through the input gate
  assign en_load = bus.data_in[EN_W-1:0];

  always_comb begin
    d_eff        = '0;
    store_val    = (bus.i == STOC) ? ~rr : rr;
    store_merged = store_val;
`ifdef ICU_LANE_MASK_EN
    d_eff        = bus.data_in & ien_r;
    // lanes with a cleared output enable keep their last stored value
    store_merged = (store_val & oen_r) | (data_out_r & ~oen_r);
`else
    d_eff        = ien_r ? bus.data_in : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EXEC;
      rr         <= '0;
      ien_r      <= '0;
      oen_r      <= '0;
      data_out_r <= '0;
      write_r    <= 1'b0;
      jmp_r      <= 1'b0;
      rtn_r      <= 1'b0;
      flag_o_r   <= 1'b0;
      flag_f_r   <= 1'b0;
    end else begin
      write_r  <= 1'b0;
      jmp_r    <= 1'b0;
      rtn_r    <= 1'b0;
      flag_o_r <= 1'b0;
      flag_f_r <= 1'b0;
      state    <= ST_EXEC;

      if (state == ST_EXEC) begin
        case (bus.i)
          LD:   rr <= d_eff;
          LDC:  rr <= ~d_eff;
          AND:  rr <= rr & d_eff;
          ANDC: rr <= rr & ~d_eff;
          OR:   rr <= rr | d_eff;
          ORC:  rr <= rr | ~d_eff;
          XNOR: rr <= ~(rr ^ d_eff);
          STO, STOC: begin
            data_out_r <= store_merged;
            write_r    <= |oen_r;
          end
          IEN:  ien_r <= en_load;
          OEN:  oen_r <= en_load;
          JMP:  jmp_r <= 1'b1;
          RTN: begin
            rtn_r <= 1'b1;
            state <= ST_SKIP;
          end
          // tests RR as it stood before this edge
          SKZ:  if (rr == '0) state <= ST_SKIP;
          NOPO: flag_o_r <= 1'b1;
          NOPF: flag_f_r <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.write    = write_r;
  assign bus.data_out = data_out_r;
  assign bus.jmp      = jmp_r;
  assign bus.rtn      = rtn_r;
  assign bus.flag_o   = flag_o_r;
  assign bus.flag_f   = flag_f_r;
  assign bus.rr_out   = rr;
  assign bus.skipping = (state == ST_SKIP);

endmodule

// File: tb/tb_icu_wide.sv
// Directed bench for icu_wide at WIDTH=8; expected values are hand-derived per scenario.
`timescale 1ns/1ps
module tb_icu_wide;
  import instructions::*;

`ifdef ICU_LANE_MASK_EN
  localparam logic [7:0] EN_ALL = 8'hFF;
`else
  localparam logic [7:0] EN_ALL = 8'h01;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  icu_wide_if #(.WIDTH(8)) bus ();

  icu_wide #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic issue(input instruction_t op, input logic [7:0] d);
    bus.i       = op;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i = NOPO; bus.data_in = 8'h00; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rr_out !== 8'h00) begin errors++; $display("FAIL reset_rr: got %h want 00", bus.rr_out); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
    checks++; if ({bus.write, bus.jmp, bus.rtn, bus.flag_o, bus.flag_f, bus.skipping} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 000000", {bus.write, bus.jmp, bus.rtn, bus.flag_o, bus.flag_f, bus.skipping}); end
    rst = 1'b0;
  endtask

  task automatic test_load_store();
    issue(IEN, EN_ALL);
    issue(OEN, EN_ALL);
    issue(LD, 8'hA5);
    checks++; if (bus.rr_out !== 8'hA5) begin errors++; $display("FAIL ld_rr: got %h want a5", bus.rr_out); end
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL ld_write: got %b want 0", bus.write); end
    issue(STO, 8'h00);
    checks++; if (bus.write !== 1'b1) begin errors++; $display("FAIL sto_write: got %b want 1", bus.write); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL sto_data: got %h want a5", bus.data_out); end
    issue(NOPO, 8'h00);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL sto_pulse_len: got %b want 0", bus.write); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL sto_hold: got %h want a5", bus.data_out); end
  endtask

  task automatic test_logic();
    issue(LD, 8'hF0);
    checks++; if (bus.rr_out !== 8'hF0) begin errors++; $display("FAIL logic_ld: got %h want f0", bus.rr_out); end
    issue(OR, 8'h0F);
    checks++; if (bus.rr_out !== 8'hFF) begin errors++; $display("FAIL logic_or: got %h want ff", bus.rr_out); end
    issue(AND, 8'h3C);
    checks++; if (bus.rr_out !== 8'h3C) begin errors++; $display("FAIL logic_and: got %h want 3c", bus.rr_out); end
    issue(STOC, 8'h00);
    checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL stoc_data: got %h want c3", bus.data_out); end
    checks++; if (bus.write !== 1'b1) begin errors++; $display("FAIL stoc_write: got %b want 1", bus.write); end
    issue(XNOR, 8'h3C);
    checks++; if (bus.rr_out !== 8'hFF) begin errors++; $display("FAIL logic_xnor: got %h want ff", bus.rr_out); end
    issue(LDC, 8'h81);
    checks++; if (bus.rr_out !== 8'h7E) begin errors++; $display("FAIL logic_ldc: got %h want 7e", bus.rr_out); end
    issue(ANDC, 8'h0F);
    checks++; if (bus.rr_out !== 8'h70) begin errors++; $display("FAIL logic_andc: got %h want 70", bus.rr_out); end
    issue(ORC, 8'hFE);
    checks++; if (bus.rr_out !== 8'h71) begin errors++; $display("FAIL logic_orc: got %h want 71", bus.rr_out); end
  endtask

  task automatic test_skz();
    issue(LD, 8'h00);
    issue(SKZ, 8'h00);
    checks++; if (bus.skipping !== 1'b1) begin errors++; $display("FAIL skz_zero_skip: got %b want 1", bus.skipping); end
    issue(LD, 8'h77);
    checks++; if (bus.rr_out !== 8'h00) begin errors++; $display("FAIL skz_rr_held: got %h want 00", bus.rr_out); end
    checks++; if (bus.skipping !== 1'b0) begin errors++; $display("FAIL skz_return: got %b want 0", bus.skipping); end
    issue(NOPO, 8'h00);
    checks++; if (bus.flag_o !== 1'b1) begin errors++; $display("FAIL skz_nopo: got %b want 1", bus.flag_o); end
    issue(LD, 8'h01);
    issue(SKZ, 8'h00);
    checks++; if (bus.skipping !== 1'b0) begin errors++; $display("FAIL skz_nonzero: got %b want 0", bus.skipping); end
    issue(LD, 8'h77);
    checks++; if (bus.rr_out !== 8'h77) begin errors++; $display("FAIL skz_no_skip_ld: got %h want 77", bus.rr_out); end
  endtask

  task automatic test_rtn();
    issue(RTN, 8'h00);
    checks++; if (bus.rtn !== 1'b1) begin errors++; $display("FAIL rtn_pulse: got %b want 1", bus.rtn); end
    checks++; if (bus.skipping !== 1'b1) begin errors++; $display("FAIL rtn_skipping: got %b want 1", bus.skipping); end
    issue(JMP, 8'h00);
    checks++; if (bus.jmp !== 1'b0) begin errors++; $display("FAIL rtn_jmp_skipped: got %b want 0", bus.jmp); end
    checks++; if (bus.rtn !== 1'b0) begin errors++; $display("FAIL rtn_pulse_len: got %b want 0", bus.rtn); end
    issue(NOPF, 8'h00);
    checks++; if (bus.flag_f !== 1'b1) begin errors++; $display("FAIL rtn_nopf: got %b want 1", bus.flag_f); end
    issue(RTN, 8'h00);
    issue(RTN, 8'h00);
    checks++; if ({bus.rtn, bus.skipping} !== 2'b00) begin errors++; $display("FAIL rtn_no_chain: got %b want 00", {bus.rtn, bus.skipping}); end
    issue(NOPO, 8'h00);
    checks++; if (bus.flag_o !== 1'b1) begin errors++; $display("FAIL rtn_nopo_exec: got %b want 1", bus.flag_o); end
  endtask

  task automatic test_jmp_flags();
    issue(JMP, 8'h00);
    checks++; if (bus.jmp !== 1'b1) begin errors++; $display("FAIL jmp_pulse: got %b want 1", bus.jmp); end
    issue(NOPF, 8'h00);
    checks++; if ({bus.jmp, bus.flag_f, bus.flag_o} !== 3'b010) begin errors++; $display("FAIL jmp_nopf: got %b want 010", {bus.jmp, bus.flag_f, bus.flag_o}); end
    issue(NOPO, 8'h00);
    checks++; if ({bus.flag_f, bus.flag_o} !== 2'b01) begin errors++; $display("FAIL nopo_only: got %b want 01", {bus.flag_f, bus.flag_o}); end
  endtask

  task automatic test_back_to_back();
    issue(LD, 8'h5A);
    issue(STO, 8'h00);
    checks++; if ({bus.write, bus.data_out} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/5a", bus.write, bus.data_out); end
    issue(STOC, 8'h00);
    checks++; if ({bus.write, bus.data_out} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/a5", bus.write, bus.data_out); end
    issue(NOPO, 8'h00);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", bus.write); end
  endtask

  task automatic test_disable();
    logic [7:0] exp_dout;
`ifdef ICU_LANE_MASK_EN
    exp_dout = 8'hA5;
`else
    exp_dout = 8'h5A;
`endif
    issue(OEN, 8'h00);
    issue(STO, 8'h00);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL oen_off_write: got %b want 0", bus.write); end
    checks++; if (bus.data_out !== exp_dout) begin errors++; $display("FAIL oen_off_data: got %h want %h", bus.data_out, exp_dout); end
    issue(IEN, 8'h00);
    issue(LD, 8'hFF);
    checks++; if (bus.rr_out !== 8'h00) begin errors++; $display("FAIL ien_off_ld: got %h want 00", bus.rr_out); end
    issue(IEN, EN_ALL);
    issue(OEN, EN_ALL);
  endtask

  task automatic test_reset_mid();
    issue(LD, 8'hC3);
    issue(RTN, 8'h00);
    checks++; if (bus.skipping !== 1'b1) begin errors++; $display("FAIL rst_pre_skip: got %b want 1", bus.skipping); end
    rst = 1'b1;
    issue(NOPO, 8'h00);
    rst = 1'b0;
    checks++; if ({bus.skipping, bus.rtn, bus.flag_o, bus.write} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_strobes: got %b want 0000", {bus.skipping, bus.rtn, bus.flag_o, bus.write}); end
    checks++; if ({bus.rr_out, bus.data_out} !== 16'h0000) begin errors++; $display("FAIL rst_mid_regs: got %h/%h want 00/00", bus.rr_out, bus.data_out); end
    issue(LD, 8'hFF);
    checks++; if (bus.rr_out !== 8'h00) begin errors++; $display("FAIL rst_ien_cleared: got %h want 00", bus.rr_out); end
    issue(STO, 8'h00);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL rst_oen_cleared: got %b want 0", bus.write); end
`ifdef ICU_LANE_MASK_EN
    issue(IEN, 8'hFF);
    issue(OEN, 8'h0F);
    issue(LD, 8'hFF);
    issue(STO, 8'h00);
    checks++; if ({bus.write, bus.data_out} !== {1'b1, 8'h0F}) begin errors++; $display("FAIL mask_sto: got %b/%h want 1/0f", bus.write, bus.data_out); end
`endif
  endtask

  initial begin
    bus.i = NOPO;
    bus.data_in = 8'h00;
    test_reset();
    test_load_store();
    test_logic();
    test_skz();
    test_rtn();
    test_jmp_flags();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icu_wide.md
Name: icu_wide

Overview:
- Parametrised successor to the 1-bit MC14500B-style industrial control unit.
- Result register (RR), input path and output path are WIDTH bits wide. Logic ops are applied bitwise across lanes.
- Same 16-instruction set from the `instructions` package (`instruction_t`), driven by an external program counter/ROM.
- Adds registered strobe timing and a skip state machine (RTN/SKZ), with optional per-lane enable masks.

Parameters:
- WIDTH, 8, data/RR lane count (>=1)

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- data_in  in  WIDTH  input data bus
- i  in  instruction_t (4)  current instruction, sampled at rising edge
- write  out  1  one-cycle store strobe
- data_out  out  WIDTH  store data, valid while write=1, held otherwise
- jmp  out  1  one-cycle JMP strobe
- rtn  out  1  one-cycle RTN strobe
- flag_o  out  1  one-cycle NOPO strobe
- flag_f  out  1  one-cycle NOPF strobe
- rr_out  out  WIDTH  current RR
- skipping  out  1  high while the currently sampled instruction is being skipped

Behaviour:
- Reset (rst=1 at rising edge): RR=0, IEN=0, OEN=0, skip=0. All strobes=0, data_out=0, skipping=0. Reset overrides any instruction in the same cycle and cancels a pending skip.
- Effective data D = IEN ? data_in : '0 (without the optional feature, IEN is 1 bit).
- State machine, two states:
  - EXEC: the sampled instruction executes.
  - SKIP: the sampled instruction is discarded (no RR/IEN/OEN change, no strobes), then the state returns to EXEC unconditionally.
  - skipping = (state == SKIP).
- Instruction effects, all in EXEC:
  - LD: RR=D
  - LDC: RR=~D
  - AND: RR&=D
  - ANDC: RR&=~D
  - OR: RR|=D
  - ORC: RR|=~D
  - XNOR: RR=~(RR^D)
  - STO: data_out=RR; write=OEN
  - STOC: data_out=~RR; write=OEN
  - IEN: IEN=data_in[0]
  - OEN: OEN=data_in[0]
  - JMP: jmp=1
  - RTN: rtn=1; next state SKIP
  - SKZ: next state SKIP iff RR==0 (all lanes zero)
  - NOPO: flag_o=1
  - NOPF: flag_f=1
- Latency:
  - Every output is registered. Strobes are high for exactly the one cycle following the sampling edge.
  - rr_out reflects the new RR one cycle after the sampling edge.
- data_out updates only on STO/STOC. If OEN=0, data_out still updates and write stays 0.
- IEN and OEN read data_in[0] directly; they are not gated by IEN.
- Back-to-back STO, STO produce two consecutive write pulses (write stays high 2 cycles).
- RTN followed by any instruction: the second instruction is skipped, including another RTN/SKZ, so skips never chain.
- SKZ checks RR before the SKZ edge. No lane is ever updated by a skipped instruction.

Optional Feature:
- Macro: ICU_LANE_MASK_EN
- Defined:
  - IEN and OEN become WIDTH-bit masks, loaded from the full data_in.
  - D = data_in & IEN.
  - On STO/STOC, data_out lanes with OEN bit=0 hold their previous value.
  - write=1 iff OEN != 0.
- Undefined:
  - 1-bit IEN/OEN as above.
  - data_out lanes all update on STO/STOC.

Test Plan (WIDTH=8):
1. Reset, then IEN with data_in=0x01, OEN with data_in=0x01, LD with data_in=0xA5, STO -> rr_out=0xA5; write=1 for one cycle with data_out=0xA5.
2. LD 0xF0, OR 0x0F, AND 0x3C, STOC -> rr_out=0x3C; data_out=0xC3; write pulse. XNOR 0x3C afterwards -> rr_out=0xFF.
3. LD 0x00, SKZ, LD 0x77, NOPO -> skipping=1 during the LD cycle; rr_out stays 0x00; flag_o pulses. Repeat with RR=0x01 -> no skip, rr_out=0x77.
4. RTN, JMP, NOPF -> rtn pulse; JMP skipped (jmp never 1); flag_f pulses. RTN, RTN, NOPO -> second RTN skipped, NOPO executes.
5. OEN with data_in=0x00, then STO -> write=0, data_out=RR. IEN with data_in=0x00, then LD 0xFF -> rr_out=0x00.
6. rst asserted in the cycle after RTN -> skipping=0, all strobes 0, RR/IEN/OEN=0. With ICU_LANE_MASK_EN: OEN 0x0F, LD 0xFF, STO after data_out=0x00 -> data_out=0x0F.
